vga_ctrl: RTL and testbench
===========================

# vga_ctrl

VGA 640x480@60 Hz timing generator for the 25 MHz pixel domain. It runs the horizontal and vertical counters and drives hsync/vsync to the connector. It requests pixels from the picture stage one cycle early through pix_x/pix_y, and registers the returned pix_data onto the RGB565 output so colour, sync and valid stay cycle-aligned.

## Interface
- H_SYNC, 96: hsync pulse width, pixels
- H_BACK, 48: horizontal back porch
- H_VALID, 640: active pixels per line
- H_FRONT, 16: horizontal front porch
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 33: vertical back porch
- V_VALID, 480: active lines
- V_FRONT, 10: vertical front porch
- vga_clk  in  1  pixel clock, 25 MHz; one clock domain only
- sys_rst  in  1  synchronous, active-high reset
- pix_data  in  16  RGB565 from picture stage, combinational response to pix_x/pix_y
- pix_x  out  10  requested X, 0..639, else 10'h3FF
- pix_y  out  10  requested Y, 0..479, else 10'h3FF
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- rgb_valid  out  1  high while the rgb output is in the active area
- rgb  out  16  RGB565 to DAC; 0 outside the active area
- frame_start  out  1  one-cycle pulse at the first cycle of each frame

## Operation
- H_TOTAL = sum of H_*, 800. V_TOTAL = sum of V_*, 525. H_ACT = H_SYNC+H_BACK (144). V_ACT = V_SYNC+V_BACK (35).
- cnt_h is 10 bits, 0..H_TOTAL-1, and increments every cycle. At H_TOTAL-1 it wraps to 0 and cnt_v advances.
- cnt_v is 10 bits, 0..V_TOTAL-1, and wraps to 0 after H_TOTAL-1 on line V_TOTAL-1.
- hsync is 0 iff cnt_h < H_SYNC. vsync is 0 iff cnt_v < V_SYNC.
- rgb_valid is 1 iff H_ACT ≤ cnt_h < H_ACT+H_VALID and V_ACT ≤ cnt_v < V_ACT+V_VALID.
- The request window is identical to rgb_valid with the horizontal bounds shifted one cycle earlier: H_ACT-1 ≤ cnt_h < H_ACT+H_VALID-1.
- Inside the request window: pix_x = cnt_h-(H_ACT-1) and pix_y = cnt_v-V_ACT. Both are 10-bit unsigned. Outside the window both are 10'h3FF.
- rgb register, each cycle: rgb <= pix_data if the request window is active, else 16'h0000.
- frame_start register: set to 1 on the cycle after cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1, i.e. it coincides with counters (0,0). Otherwise 0.
- No state machine beyond the two counters. The line and frame phases are pure decodes of the counters.
- Reset mid-frame: both counters and all registers return to reset values on the next edge. The next frame starts cleanly from (0,0), and no frame_start pulse is produced by the reset itself.

## Timing
- Reset values: cnt_h=0, cnt_v=0, rgb=0, frame_start=0. The decoded outputs follow from (0,0): hsync=0, vsync=0, rgb_valid=0, pix_x=pix_y=10'h3FF.
- Latency from pix_x/pix_y to rgb is exactly 1 cycle. rgb and rgb_valid are aligned: the first active rgb appears at cnt_h=144.
- The request for pixel (0,y) is made at cnt_h=143, and pixel (639,y) at cnt_h=782. rgb_valid is high for cnt_h 144..783.
- hsync, vsync, rgb_valid and pix_x/pix_y are combinational decodes of registered counters only. No input affects them.
- Frame period is 800×525 = 420000 cycles. frame_start repeats every 420000 cycles.

## Structure
- The timing constants (H_*, V_*, H_TOTAL, V_TOTAL, H_ACT, V_ACT) and the colour constants (BLACK, WHITE, BLUE) go in a shared include, vga_param.vh. The picture stage and this block both use it.
- Single module, no sub-module. The counters and decode are too small to split.
- The top level wires pix_x/pix_y/pix_data between vga_ctrl and vga_pic_must.

## Test plan
- Reset: hold sys_rst for 5 cycles, then release. Counters read (0,0), hsync=0, vsync=0, pix_x=3FF, rgb=0. frame_start stays 0 until cycle 420000 after release.
- Line timing at cnt_v=35:
  - hsync low for exactly 96 cycles per line.
  - pix_x=0 at cnt_h=143 and 639 at cnt_h=782, then 3FF at cnt_h=783.
  - rgb_valid high for exactly 640 cycles.
- Frame timing:
  - vsync low for 2×800 = 1600 cycles.
  - pix_y runs 0 at cnt_v=35 to 479 at cnt_v=514.
  - rgb_valid is high for 307200 cycles per frame.
  - frame_start pulses every 420000 cycles.
- Data path: drive pix_data = {pix_x[4:0], pix_y[5:0], pix_x[4:0]} from a bench model. rgb on each valid cycle must equal the model value for the previous cycle's pix_x/pix_y. rgb is 0 on every non-valid cycle.
- Blanking: with pix_data forced to 16'hFFFF, rgb=0 in all porch and sync cycles, and rgb=FFFF exactly when rgb_valid=1.
- Mid-frame reset: assert sys_rst at cnt_h=400, cnt_v=200 for one cycle. The next cycle shows (0,0), rgb=0 and no frame_start pulse. Timing then repeats identically to the post-reset sequence.

Source files
------------

// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - VGA 640x480@60 timing and colour constants shared by vga_ctrl and the picture stage
package vga_ctrl_pkg;

    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_VALID = 640;
    localparam int H_FRONT = 16;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLUE  = 16'h001F;

endpackage

// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator: h/v counters, sync decode, one-cycle-early pixel request, registered RGB
module vga_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int HS = H_SYNC,
    parameter int HB = H_BACK,
    parameter int HV = H_VALID,
    parameter int HF = H_FRONT,
    parameter int VS = V_SYNC,
    parameter int VB = V_BACK,
    parameter int VV = V_VALID,
    parameter int VF = V_FRONT
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] HT_M1   = 10'(HS + HB + HV + HF - 1);
    localparam logic [9:0] VT_M1   = 10'(VS + VB + VV + VF - 1);
    localparam logic [9:0] HS_END  = 10'(HS);
    localparam logic [9:0] VS_END  = 10'(VS);
    localparam logic [9:0] HA_BEG  = 10'(HS + HB);
    localparam logic [9:0] HA_END  = 10'(HS + HB + HV);
    localparam logic [9:0] HR_BEG  = 10'(HS + HB - 1);
    localparam logic [9:0] HR_END  = 10'(HS + HB + HV - 1);
    localparam logic [9:0] VA_BEG  = 10'(VS + VB);
    localparam logic [9:0] VA_END  = 10'(VS + VB + VV);

    logic [9:0]  cnt_h_q, cnt_h_d;
    logic [9:0]  cnt_v_q, cnt_v_d;
    logic [15:0] rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;

    logic h_end, v_end, v_act, h_act, h_req, req_act;

    always_comb begin
        h_end   = (cnt_h_q == HT_M1);
        v_end   = (cnt_v_q == VT_M1);
        v_act   = (cnt_v_q >= VA_BEG) && (cnt_v_q < VA_END);
        h_act   = (cnt_h_q >= HA_BEG) && (cnt_h_q < HA_END);
        // Request window leads the active window by one cycle to cover the rgb register.
        h_req   = (cnt_h_q >= HR_BEG) && (cnt_h_q < HR_END);
        req_act = h_req && v_act;

        cnt_h_d = h_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d = cnt_v_q;
        if (h_end) begin
            cnt_v_d = v_end ? 10'd0 : cnt_v_q + 10'd1;
        end
        rgb_d         = req_act ? pix_data : BLACK;
        frame_start_d = h_end && v_end;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt_h_q       <= 10'd0;
            cnt_v_q       <= 10'd0;
            rgb_q         <= 16'h0000;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = (cnt_h_q >= HS_END);
    assign vsync       = (cnt_v_q >= VS_END);
    assign rgb_valid   = h_act && v_act;
    assign pix_x       = req_act ? (cnt_h_q - HR_BEG) : 10'h3FF;
    assign pix_y       = req_act ? (cnt_v_q - VA_BEG) : 10'h3FF;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - randomized self-checking bench for vga_ctrl: full-size and reduced-geometry instances vs a frame-position model
module tb_vga_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_f = 1'b1, rst_s = 1'b1;
    logic [9:0]  px_f, py_f, px_s, py_s;
    logic        hs_f, vs_f, rv_f, fs_f, hs_s, vs_s, rv_s, fs_s;
    logic [15:0] rgb_f, rgb_s, pd_f, pd_s;
    logic [15:0] salt_f = 16'h0, salt_s = 16'h0;
    logic        mode_f = 1'b0, mode_s = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [15:0] pat(input logic [9:0] x, input logic [9:0] y);
        return {x[4:0], y[5:0], x[4:0]};
    endfunction

    assign pd_f = mode_f ? 16'hFFFF : (pat(px_f, py_f) ^ salt_f);
    assign pd_s = mode_s ? 16'hFFFF : (pat(px_s, py_s) ^ salt_s);

    vga_ctrl dut_f (
        .vga_clk(clk), .sys_rst(rst_f), .pix_data(pd_f), .pix_x(px_f), .pix_y(py_f),
        .hsync(hs_f), .vsync(vs_f), .rgb_valid(rv_f), .rgb(rgb_f), .frame_start(fs_f)
    );

    vga_ctrl #(.HS(8), .HB(4), .HV(16), .HF(4), .VS(2), .VB(3), .VV(10), .VF(2)) dut_s (
        .vga_clk(clk), .sys_rst(rst_s), .pix_data(pd_s), .pix_x(px_s), .pix_y(py_s),
        .hsync(hs_s), .vsync(vs_s), .rgb_valid(rv_s), .rgb(rgb_s), .frame_start(fs_s)
    );

    // Geometry per instance: 0 = 640x480 default, 1 = reduced 32x17 frame.
    int hsw[2] = '{96, 8};
    int ha[2]  = '{144, 12};
    int hvl[2] = '{640, 16};
    int ht[2]  = '{800, 32};
    int vsw[2] = '{2, 2};
    int va[2]  = '{35, 5};
    int vvl[2] = '{480, 10};
    int vt[2]  = '{525, 17};

    int          p[2]        = '{0, 0};
    bit          live[2]     = '{0, 0};
    bit          rst_prev[2] = '{0, 0};
    logic [15:0] rgb_next[2] = '{16'h0, 16'h0};
    int          hs_lo[2]    = '{0, 0};
    int          rv_line[2]  = '{0, 0};
    int          rv_frame[2] = '{0, 0};
    int          vs_lo[2]    = '{0, 0};

    task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d, pos %0d]: got %0h, expected %0h", nm, k, p[k], act, exp);
        end
    endtask

    task automatic check(input int k, input logic rst_now, input logic hs, input logic vs,
                         input logic rv, input logic fs, input logic [9:0] px, input logic [9:0] py,
                         input logic [15:0] rgb, input logic [15:0] salt, input logic mode);
        int h, v;
        bit win, vact, hact;
        logic [15:0] er;
        logic ef;
        logic [9:0] ex, ey;
        if (!rst_prev[k] && !live[k]) begin
            rst_prev[k] = rst_now;
            return;
        end
        if (rst_prev[k]) begin
            p[k] = 0; live[k] = 1; er = 16'h0; ef = 1'b0;
        end else begin
            p[k] = (p[k] + 1) % (ht[k] * vt[k]);
            er = rgb_next[k];
            ef = (p[k] == 0);
        end
        h = p[k] % ht[k];
        v = p[k] / ht[k];
        vact = (v >= va[k]) && (v < va[k] + vvl[k]);
        hact = (h >= ha[k]) && (h < ha[k] + hvl[k]);
        win  = vact && (h >= ha[k] - 1) && (h < ha[k] + hvl[k] - 1);
        ex = win ? 10'(h - (ha[k] - 1)) : 10'h3FF;
        ey = win ? 10'(v - va[k]) : 10'h3FF;

        cmp("hsync", k, 32'(hs), 32'(h >= hsw[k]));
        cmp("vsync", k, 32'(vs), 32'(v >= vsw[k]));
        cmp("rgb_valid", k, 32'(rv), 32'(vact && hact));
        cmp("pix_x", k, 32'(px), 32'(ex));
        cmp("pix_y", k, 32'(py), 32'(ey));
        cmp("rgb", k, 32'(rgb), 32'(er));
        cmp("frame_start", k, 32'(fs), 32'(ef));

        rgb_next[k] = win ? (mode ? 16'hFFFF : (pat(ex, ey) ^ salt)) : 16'h0;

        if (h == 0) begin hs_lo[k] = 0; rv_line[k] = 0; end
        if (p[k] == 0) begin rv_frame[k] = 0; vs_lo[k] = 0; end
        if (!hs) hs_lo[k]++;
        if (!vs) vs_lo[k]++;
        if (rv) begin rv_line[k]++; rv_frame[k]++; end
        if (h == ht[k] - 1) begin
            cmp("hsync_low_per_line", k, 32'(hs_lo[k]), 32'(hsw[k]));
            cmp("rgb_valid_per_line", k, 32'(rv_line[k]), vact ? 32'(hvl[k]) : 32'd0);
        end
        if (p[k] == ht[k] * vt[k] - 1) begin
            cmp("rgb_valid_per_frame", k, 32'(rv_frame[k]), 32'(hvl[k] * vvl[k]));
            cmp("vsync_low_per_frame", k, 32'(vs_lo[k]), 32'(vsw[k] * ht[k]));
        end

        if (k == 0) begin
            if (p[k] == 0 && rst_prev[k]) begin
                cmp("lit_reset_pix_x", k, 32'(px), 32'h3FF);
                cmp("lit_reset_hsync", k, 32'(hs), 32'd0);
                cmp("lit_reset_vsync", k, 32'(vs), 32'd0);
                cmp("lit_reset_rgb", k, 32'(rgb), 32'd0);
            end
            if (p[k] == 1599) cmp("lit_vsync_last_low", k, 32'(vs), 32'd0);
            if (p[k] == 1600) cmp("lit_vsync_first_high", k, 32'(vs), 32'd1);
            if (p[k] == 28143) begin
                cmp("lit_pix_x_first", k, 32'(px), 32'd0);
                cmp("lit_pix_y_first", k, 32'(py), 32'd0);
                cmp("lit_rgb_valid_pre", k, 32'(rv), 32'd0);
            end
            if (p[k] == 28144) cmp("lit_rgb_valid_first", k, 32'(rv), 32'd1);
            if (p[k] == 28782) cmp("lit_pix_x_last", k, 32'(px), 32'd639);
            if (p[k] == 28783) begin
                cmp("lit_pix_x_after", k, 32'(px), 32'h3FF);
                cmp("lit_rgb_valid_last", k, 32'(rv), 32'd1);
            end
            if (p[k] == 28784) cmp("lit_rgb_valid_after", k, 32'(rv), 32'd0);
            if (p[k] == 28799) begin
                cmp("lit_hsync_low_96", k, 32'(hs_lo[k]), 32'd96);
                cmp("lit_rgb_valid_640", k, 32'(rv_line[k]), 32'd640);
            end
        end else begin
            if (p[k] == 171) cmp("lit_s_pix_x_first", k, 32'(px), 32'd0);
            if (p[k] == 543) begin
                cmp("lit_s_rgb_valid_160", k, 32'(rv_frame[k]), 32'd160);
                cmp("lit_s_vsync_low_64", k, 32'(vs_lo[k]), 32'd64);
            end
        end
        rst_prev[k] = rst_now;
    endtask

    always @(negedge clk) begin
        check(0, rst_f, hs_f, vs_f, rv_f, fs_f, px_f, py_f, rgb_f, salt_f, mode_f);
        check(1, rst_s, hs_s, vs_s, rv_s, fs_s, px_s, py_s, rgb_s, salt_s, mode_s);
    end

    bit mid_done = 0;

    initial begin
        repeat (5) @(posedge clk);
        #2;
        rst_f = 1'b0;
        rst_s = 1'b0;
        for (int c = 0; c < 28900; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 199) == 0) begin
                mode_f = ($urandom_range(0, 2) == 0);
                salt_f = 16'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                mode_s = ($urandom_range(0, 2) == 0);
                salt_s = 16'($urandom);
            end
            rst_s = 1'b0;
            // Model position lags the DUT by one cycle here, so target-1 means the DUT sits at (20,8).
            if (!mid_done && c > 1500 && p[1] == 8 * 32 + 20 - 1) begin
                rst_s = 1'b1;
                mid_done = 1;
            end else if (c > 6000 && $urandom_range(0, 1499) == 0) begin
                rst_s = 1'b1;
            end
        end
        cmp("mid_reset_done", 1, 32'(mid_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
